// File: rtl/ir_frame_tx_pkg.sv
// Shared definitions for the NEC IR frame transmitter: FSM states, segment lengths
// in NEC units, and small helpers for payload assembly and mark detection.
package ir_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } ir_state_e;

  localparam int unsigned LEAD_MARK_UNITS  = 32'd16;
  localparam int unsigned LEAD_SPACE_UNITS = 32'd8;
  localparam int unsigned BIT_UNITS        = 32'd1;
  localparam int unsigned ONE_SPACE_UNITS  = 32'd3;
  localparam int unsigned STOP_UNITS       = 32'd1;
  localparam logic [4:0]  LAST_BIT         = 5'd31;

  // Bit 0 goes on air first, so the address byte leads.
  function automatic logic [31:0] nec_payload(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  function automatic logic is_mark(input ir_state_e st);
    logic mark;
    case (st)
      ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK: mark = 1'b1;
      default:                                 mark = 1'b0;
    endcase
    return mark;
  endfunction

endpackage

// File: rtl/ir_frame_tx_carrier_gen.sv
// Carrier generator: free-running period counter with a duty compare; the output is
// registered from the next count so it lines up with the cycle a mark begins.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 2632,
  parameter int unsigned CARRIER_HI  = 877
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic carrier
);

  localparam int unsigned   CW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CNT_HI   = CW'(CARRIER_HI);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;

  // next carrier phase
  always_comb begin
    cnt_nx_s = '0;
    if (restart || (cnt_r == CNT_LAST)) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  // phase counter and gated carrier output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= '0;
      carrier <= 1'b0;
    end else begin
      cnt_r   <= cnt_nx_s;
      carrier <= en && (cnt_nx_s < CNT_HI);
    end
  end

endmodule

// File: rtl/ir_frame_tx.sv
// NEC IR transmitter: one modulated frame per rising edge of ready, with a single-deep
// request queue while a frame (including its trailing gap) is on air.
module ir_frame_tx
  import ir_frame_tx_pkg::*;
#(
  parameter int unsigned CARRIER_DIV = 2632,
  parameter int unsigned CARRIER_HI  = 877,
  parameter int unsigned UNIT_CYC    = 56200,
  parameter logic [7:0]  ADDR        = 8'h00,
  parameter int unsigned GAP_UNITS   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] cmd,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  localparam int unsigned   UW        = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int unsigned   SEG_MAX   = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int unsigned   SW        = $clog2(SEG_MAX + 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
  localparam logic [SW-1:0] SEG_ONE   = SW'(1);

  ir_state_e     state_r;
  logic          ready_d_r;
  logic          pending_r;
  logic          busy_r;
  logic          done_r;
  logic          dropped_r;
  logic [UW-1:0] unit_cnt_r;
  logic [SW-1:0] seg_cnt_r;
  logic [4:0]    bit_idx_r;
  logic [31:0]   shift_r;

  logic req_s;
  logic tick_s;
  logic seg_end_s;
  logic start_s;
  logic enter_mark_s;
  logic mark_en_s;

  // request edge, segment timing and carrier control for the upcoming cycle
  always_comb begin
    req_s        = ready & ~ready_d_r;
    tick_s       = (state_r != ST_IDLE) && (unit_cnt_r == UNIT_LAST);
    seg_end_s    = tick_s && (seg_cnt_r == SEG_ONE);
    start_s      = 1'b0;
    enter_mark_s = 1'b0;
    mark_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: start_s = req_s;
      ST_GAP:  start_s = seg_end_s && (pending_r || req_s);
      default: start_s = 1'b0;
    endcase
    case (state_r)
      ST_LEAD_SPACE, ST_BIT_SPACE: enter_mark_s = start_s || seg_end_s;
      default:                     enter_mark_s = start_s;
    endcase
    if (enter_mark_s) begin
      mark_en_s = 1'b1;
    end else if (is_mark(state_r)) begin
      mark_en_s = !seg_end_s;
    end else begin
      mark_en_s = 1'b0;
    end
  end

  // frame sequencer, counters, request queue and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ready_d_r  <= 1'b0;
      pending_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dropped_r  <= 1'b0;
      unit_cnt_r <= '0;
      seg_cnt_r  <= '0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
    end else begin
      ready_d_r <= ready;
      done_r    <= 1'b0;
      dropped_r <= 1'b0;
      if ((state_r == ST_IDLE) || tick_s) begin
        unit_cnt_r <= '0;
      end else begin
        unit_cnt_r <= unit_cnt_r + UW'(1);
      end
      if (tick_s) begin
        seg_cnt_r <= seg_cnt_r - SW'(1);
      end
      if (start_s) begin
        // a req landing on the gap's last cycle while one is queued stays queued
        state_r    <= ST_LEAD_MARK;
        seg_cnt_r  <= SW'(LEAD_MARK_UNITS);
        unit_cnt_r <= '0;
        bit_idx_r  <= '0;
        shift_r    <= nec_payload(ADDR, cmd);
        busy_r     <= 1'b1;
        pending_r  <= pending_r & req_s;
      end else begin
        if (req_s && (state_r != ST_IDLE)) begin
          if (pending_r) begin
            dropped_r <= 1'b1;
          end else begin
            pending_r <= 1'b1;
          end
        end
        if (seg_end_s) begin
          case (state_r)
            ST_LEAD_MARK: begin
              state_r   <= ST_LEAD_SPACE;
              seg_cnt_r <= SW'(LEAD_SPACE_UNITS);
            end
            ST_LEAD_SPACE: begin
              state_r   <= ST_BIT_MARK;
              seg_cnt_r <= SW'(BIT_UNITS);
            end
            ST_BIT_MARK: begin
              state_r   <= ST_BIT_SPACE;
              seg_cnt_r <= shift_r[0] ? SW'(ONE_SPACE_UNITS) : SW'(BIT_UNITS);
            end
            ST_BIT_SPACE: begin
              if (bit_idx_r == LAST_BIT) begin
                state_r   <= ST_STOP_MARK;
                seg_cnt_r <= SW'(STOP_UNITS);
              end else begin
                state_r   <= ST_BIT_MARK;
                seg_cnt_r <= SW'(BIT_UNITS);
                bit_idx_r <= bit_idx_r + 5'd1;
                shift_r   <= {1'b0, shift_r[31:1]};
              end
            end
            ST_STOP_MARK: begin
              state_r   <= ST_GAP;
              seg_cnt_r <= SW'(GAP_UNITS);
              done_r    <= 1'b1;
            end
            ST_GAP: begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
            default: begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV),
    .CARRIER_HI (CARRIER_HI)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .restart(enter_mark_s),
    .en     (mark_en_s),
    .carrier(out)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign dropped = dropped_r;

endmodule

// File: tb/tb_ir_frame_tx.sv
// Directed bench for ir_frame_tx with small timing parameters: every frame is walked
// cycle by cycle against an independently built mark/space timeline.
module tb_ir_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] cmd;
  logic       out;
  logic       busy;
  logic       done;
  logic       dropped;

  int tests = 0;
  int fails = 0;

  // With ADDR=0 every frame has 16 one bits: 125 units of 12 cycles
  localparam int FRAME_CYC = 1500;
  localparam int DONE_CYC  = 1452;
  localparam int DROP_CYC  = 307;

  logic wave [0:FRAME_CYC-1];

  always #5 clk = ~clk;

  ir_frame_tx #(
    .CARRIER_DIV(6),
    .CARRIER_HI (2),
    .UNIT_CYC   (12),
    .ADDR       (8'h00),
    .GAP_UNITS  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .cmd    (cmd),
    .out    (out),
    .busy   (busy),
    .done   (done),
    .dropped(dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Space length after each 12-cycle bit mark: 12 zeros for a 0 bit, 36 for a 1 bit
  function automatic logic [31:0] decode_wave();
    int pos = 288;
    int z;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 32; i++) begin
      pos += 12;
      z = 0;
      while (pos < FRAME_CYC && wave[pos] == 1'b0) begin
        z++;
        pos++;
      end
      v[i] = (z > 24);
    end
    return v;
  endfunction

  // Called in cycle 0 of a frame; returns in the cycle after the gap ends
  task automatic walk_frame(input logic [31:0] payload, input int edges,
                            input logic [7:0] late_cmd, input string tag);
    int   seg_len [68];
    logic seg_mark[68];
    int   si = 0;
    int   off = 0;
    int   out_err = 0, busy_err = 0, done_err = 0, drop_err = 0;
    logic exp_out;
    seg_len[0] = 192; seg_mark[0] = 1'b1;
    seg_len[1] = 96;  seg_mark[1] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      seg_len[2 + 2*i] = 12;                      seg_mark[2 + 2*i] = 1'b1;
      seg_len[3 + 2*i] = payload[i] ? 36 : 12;    seg_mark[3 + 2*i] = 1'b0;
    end
    seg_len[66] = 12; seg_mark[66] = 1'b1;
    seg_len[67] = 48; seg_mark[67] = 1'b0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      exp_out = seg_mark[si] && ((off % 6) < 2);
      wave[c] = out;
      if (out !== exp_out) out_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== (c == DONE_CYC)) done_err++;
      if (dropped !== ((edges >= 2) && (c == DROP_CYC))) drop_err++;
      if (edges >= 1 && c == 300) ready = 1'b0;
      if (edges >= 1 && c == 302) ready = 1'b1;
      if (edges >= 2 && c == 304) ready = 1'b0;
      if (edges >= 2 && c == 306) ready = 1'b1;
      if (c == 400) cmd = late_cmd;
      off++;
      if (off == seg_len[si]) begin
        off = 0;
        if (si < 67) si++;
      end
      tick();
    end
    check($sformatf("%s out_wave_errs", tag), out_err, 0);
    check($sformatf("%s busy_errs", tag), busy_err, 0);
    check($sformatf("%s done_errs", tag), done_err, 0);
    check($sformatf("%s dropped_errs", tag), drop_err, 0);
    check($sformatf("%s decoded_bits", tag), decode_wave(), payload);
  endtask

  initial begin
    int idle_err;
    rst   = 1'b0;
    ready = 1'b0;
    cmd   = 8'h00;
    repeat (3) tick();
    check("rst out", out, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst dropped", dropped, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    check("idle busy", busy, 1'b0);

    // single request, cmd 03
    cmd   = 8'h03;
    ready = 1'b1;
    tick();
    walk_frame(32'hFC03FF00, 0, 8'h03, "t1");

    // ready stays high: no second frame
    idle_err = 0;
    for (int k = 0; k < 8500; k++) begin
      if (busy !== 1'b0 || out !== 1'b0 || dropped !== 1'b0) idle_err++;
      tick();
    end
    check("t2 held_high_idle_errs", idle_err, 0);

    // new edge, two more edges mid-frame, cmd changed while pending
    ready = 1'b0;
    tick();
    cmd   = 8'h05;
    ready = 1'b1;
    tick();
    walk_frame(32'hFA05FF00, 2, 8'h0A, "t3");
    walk_frame(32'hF50AFF00, 0, 8'h0A, "t4");
    check("t4 busy_after", busy, 1'b0);

    // async reset in the first bit space, ready high at release
    ready = 1'b0;
    tick();
    cmd   = 8'h03;
    ready = 1'b1;
    tick();
    repeat (305) tick();
    check("t5 busy_before_rst", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("t5 async busy", busy, 1'b0);
    check("t5 async out", out, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    walk_frame(32'hFC03FF00, 0, 8'h03, "t5");
    check("t5 busy_after", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
